// File: rtl/mult_issue_ctrl.sv
// rtl/mult_issue_ctrl.sv - RV32M multiplier issue controller: request accept, start/done launch, response hold
`ifndef DEFAULT_MULT_LATENCY
`define DEFAULT_MULT_LATENCY 2
`endif

module mult_issue_ctrl #(
    parameter int unsigned LATENCY        = `DEFAULT_MULT_LATENCY,
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_rs1_i,
    input  logic [31:0] req_rs2_i,
    input  logic [4:0]  req_rd_i,

    input  logic        flush_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_result_o,
    output logic [4:0]  rsp_rd_o,
    output logic        rsp_error_o,

    output logic        mult_start_o,
    output logic [2:0]  mult_op_type_o,
    output logic [31:0] mult_operand_a_o,
    output logic [31:0] mult_operand_b_o,
    input  logic [31:0] mult_result_i,
    input  logic        mult_done_i,
    input  logic        mult_exception_valid_i
);

    // A timeout at or below the pipeline depth would fire on healthy ops, so clamp it above LATENCY.
    localparam int unsigned      TIMEOUT_EFF = (TIMEOUT_CYCLES > LATENCY) ? TIMEOUT_CYCLES : LATENCY + 1;
    localparam int unsigned      CNT_W       = $clog2(TIMEOUT_EFF + 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_EFF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       rd_q;
    logic             accept;
    logic             timeout_hit;

    assign req_ready_o = rst_ni && !flush_i &&
                         ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready_i));
    assign accept      = req_valid_i && req_ready_o;
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            rd_q             <= '0;
            rsp_valid_o      <= 1'b0;
            rsp_result_o     <= '0;
            rsp_rd_o         <= '0;
            rsp_error_o      <= 1'b0;
            mult_start_o     <= 1'b0;
            mult_op_type_o   <= '0;
            mult_operand_a_o <= '0;
            mult_operand_b_o <= '0;
        end else begin
            mult_start_o <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    state_q <= S_IDLE;
                end

                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= flush_i ? S_DRAIN : S_WAIT;
                end

                S_WAIT: begin
                    if (flush_i) begin
                        cnt_q   <= '0;
                        state_q <= S_DRAIN;
                    end else if (mult_done_i) begin
                        rsp_valid_o  <= 1'b1;
                        rsp_result_o <= mult_result_i;
                        rsp_error_o  <= mult_exception_valid_i;
                        rsp_rd_o     <= rd_q;
                        state_q      <= S_RESP;
                    end else if (timeout_hit) begin
                        rsp_valid_o  <= 1'b1;
                        rsp_result_o <= '0;
                        rsp_error_o  <= 1'b1;
                        rsp_rd_o     <= rd_q;
                        state_q      <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_RESP: begin
                    if (flush_i || rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end

                // Absorb the killed op's done so it cannot complete the next request.
                S_DRAIN: begin
                    if (mult_done_i || timeout_hit) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // Accept is only possible from IDLE or a completing RESP, so it overrides the case above.
            if (accept) begin
                if (req_funct3_i[2]) begin
                    rsp_valid_o  <= 1'b1;
                    rsp_result_o <= '0;
                    rsp_error_o  <= 1'b1;
                    rsp_rd_o     <= req_rd_i;
                    state_q      <= S_RESP;
                end else begin
                    mult_op_type_o   <= req_funct3_i;
                    mult_operand_a_o <= req_rs1_i;
                    mult_operand_b_o <= req_rs2_i;
                    rd_q             <= req_rd_i;
                    mult_start_o     <= 1'b1;
                    state_q          <= S_ISSUE;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// tb/tb_mult_issue_ctrl.sv - scoreboard bench for mult_issue_ctrl with a fixed-latency multiplier stub
module tb_mult_issue_ctrl;

    localparam int LAT = 2;
    localparam int TO  = 32;

    localparam int K_OK   = 0;
    localparam int K_ILL  = 1;
    localparam int K_TMO  = 2;
    localparam int K_NONE = 3;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_rs1_i;
    logic [31:0] req_rs2_i;
    logic [4:0]  req_rd_i;
    logic        flush_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_result_o;
    logic [4:0]  rsp_rd_o;
    logic        rsp_error_o;
    logic        mult_start_o;
    logic [2:0]  mult_op_type_o;
    logic [31:0] mult_operand_a_o;
    logic [31:0] mult_operand_b_o;
    logic [31:0] mult_result_i;
    logic        mult_done_i;
    logic        mult_exception_valid_i;

    mult_issue_ctrl #(
        .LATENCY        (LAT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .req_valid_i            (req_valid_i),
        .req_ready_o            (req_ready_o),
        .req_funct3_i           (req_funct3_i),
        .req_rs1_i              (req_rs1_i),
        .req_rs2_i              (req_rs2_i),
        .req_rd_i               (req_rd_i),
        .flush_i                (flush_i),
        .rsp_valid_o            (rsp_valid_o),
        .rsp_ready_i            (rsp_ready_i),
        .rsp_result_o           (rsp_result_o),
        .rsp_rd_o               (rsp_rd_o),
        .rsp_error_o            (rsp_error_o),
        .mult_start_o           (mult_start_o),
        .mult_op_type_o         (mult_op_type_o),
        .mult_operand_a_o       (mult_operand_a_o),
        .mult_operand_b_o       (mult_operand_b_o),
        .mult_result_i          (mult_result_i),
        .mult_done_i            (mult_done_i),
        .mult_exception_valid_i (mult_exception_valid_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t exp_rsp_q[$];
    int   exp_start_q[$];
    int   checks      = 0;
    int   failures    = 0;
    int   starts_exp  = 0;
    int   starts_seen = 0;
    logic stub_hang   = 1'b0;
    logic stub_exc    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mul_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (f == 3'b001 || f == 3'b010) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (f == 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (f == 3'b000) ? p[31:0] : p[63:32];
    endfunction

    // Multiplier stub: done arrives LAT cycles after the start cycle unless hung.
    initial begin : stub
        int          rem;
        logic        nd;
        logic [31:0] pend;
        logic [31:0] nres;
        rem = 0;
        pend = '0;
        mult_done_i = 1'b0;
        mult_result_i = '0;
        mult_exception_valid_i = 1'b0;
        forever begin
            @(negedge clk_i);
            nd   = (rem == 1) && !stub_hang;
            nres = pend;
            if (rem > 0) rem--;
            if (mult_start_o) begin
                pend = mul_model(mult_op_type_o, mult_operand_a_o, mult_operand_b_o);
                rem  = LAT - 1;
            end
            @(posedge clk_i);
            #1;
            mult_done_i            = nd;
            mult_result_i          = nd ? nres : 32'h0;
            mult_exception_valid_i = nd && stub_exc;
        end
    end

    initial begin : monitor
        exp_t        e;
        int          t0;
        int          s;
        logic [37:0] snap;
        logic        unstable;
        logic        active;
        active = 1'b0;
        unstable = 1'b0;
        t0 = 0;
        snap = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                active = 1'b0;
            end else begin
                if (mult_start_o) begin
                    starts_seen++;
                    if (exp_start_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL start_unexpected actual=1 expected=0 cycle=%0d", cyc);
                    end else begin
                        s = exp_start_q.pop_front();
                        chk("start_cycle", cyc, s);
                    end
                end
                if (rsp_valid_o) begin
                    if (!active) begin
                        active   = 1'b1;
                        t0       = cyc;
                        snap     = {rsp_result_o, rsp_rd_o, rsp_error_o};
                        unstable = 1'b0;
                    end else if ({rsp_result_o, rsp_rd_o, rsp_error_o} !== snap) begin
                        unstable = 1'b1;
                    end
                    if (rsp_ready_i && !flush_i) begin
                        active = 1'b0;
                        if (exp_rsp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL rsp_unexpected actual=1 expected=0 cycle=%0d", cyc);
                        end else begin
                            e = exp_rsp_q.pop_front();
                            chk("rsp_result", rsp_result_o, e.res);
                            chk("rsp_rd", 32'(rsp_rd_o), 32'(e.rd));
                            chk("rsp_error", 32'(rsp_error_o), 32'(e.err));
                            chk("rsp_first_cycle", t0, e.cyc);
                            chk("rsp_stable", 32'(unstable), 32'd0);
                        end
                    end
                end else begin
                    active = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int kind, input logic [31:0] exp_res,
                         input logic exp_err, output int t_acc);
        exp_t e;
        int   n;
        n     = 0;
        t_acc = -1;
        req_valid_i  = 1'b1;
        req_funct3_i = f3;
        req_rs1_i    = a;
        req_rs2_i    = b;
        req_rd_i     = rd;
        while (t_acc < 0 && n < 200) begin
            @(negedge clk_i);
            if (req_ready_o) t_acc = cyc;
            @(posedge clk_i);
            #1;
            n++;
        end
        req_valid_i = 1'b0;
        if (t_acc < 0) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=none expected=accept rd=%0d", rd);
        end else begin
            if (!f3[2]) begin
                exp_start_q.push_back(t_acc + 1);
                starts_exp++;
            end
            if (kind != K_NONE) begin
                e.res = exp_res;
                e.rd  = rd;
                e.err = exp_err;
                e.cyc = (kind == K_ILL) ? t_acc + 1 : (kind == K_TMO) ? t_acc + 2 + TO : t_acc + 2 + LAT;
                exp_rsp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_rsp_q.size() != 0 && n < 300) begin
            @(posedge clk_i);
            n++;
        end
        #1;
        chk("drain_pending", exp_rsp_q.size(), 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rsp_result"}, rsp_result_o, 32'h0);
        chk({tag, "_operand_a"}, mult_operand_a_o, 32'h0);
        chk({tag, "_operand_b"}, mult_operand_b_o, 32'h0);
        chk({tag, "_ctrl_bits"}, 32'({req_ready_o, rsp_valid_o, rsp_rd_o, rsp_error_o,
                                      mult_start_o, mult_op_type_o}), 32'h0);
    endtask

    initial begin : stimulus
        int t0;
        int t1;
        int t2;
        int t3;
        int tb_acc;
        int rel;
        int n;
        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        req_funct3_i = '0;
        req_rs1_i    = '0;
        req_rs2_i    = '0;
        req_rd_i     = '0;
        flush_i      = 1'b0;
        rsp_ready_i  = 1'b1;

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk_outputs_zero("reset");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("idle_ready", 32'(req_ready_o), 32'd1);
        @(posedge clk_i);
        #1;

        // Back-to-back ops with writeback always ready: one accept every LAT+2 cycles.
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, K_OK, 32'hFFFF_FFFE, 1'b0, t0);
        issue(3'b000, 32'hFFFF_FFFF, 32'h0000_0003, 5'd6, K_OK, 32'hFFFF_FFFD, 1'b0, t1);
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd7, K_OK, 32'h4000_0000, 1'b0, t2);
        issue(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8, K_OK, 32'hFFFF_FFFF, 1'b0, t3);
        chk("b2b_gap_1", t1 - t0, LAT + 2);
        chk("b2b_gap_2", t2 - t1, LAT + 2);
        chk("b2b_gap_3", t3 - t2, LAT + 2);
        wait_drain();

        issue(3'b100, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9, K_ILL, 32'h0, 1'b1, t0);
        issue(3'b111, 32'h0000_0001, 32'h0000_0001, 5'd10, K_ILL, 32'h0, 1'b1, t1);
        wait_drain();

        // Writeback stalls 5 cycles; the queued request is taken in the release cycle.
        rsp_ready_i = 1'b0;
        issue(3'b000, 32'd5, 32'd5, 5'd3, K_OK, 32'd25, 1'b0, t0);
        rel = -1;
        fork
            issue(3'b011, 32'h0001_0000, 32'h0001_0000, 5'd4, K_OK, 32'h0000_0001, 1'b0, tb_acc);
            begin
                n = 0;
                while (!rsp_valid_o && n < 50) begin
                    @(negedge clk_i);
                    n++;
                end
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk_i);
                    chk("stall_req_ready", 32'(req_ready_o), 32'd0);
                    @(posedge clk_i);
                    #1;
                end
                rel = cyc;
                rsp_ready_i = 1'b1;
            end
        join
        chk("stall_release_accept", tb_acc, rel);
        wait_drain();

        stub_exc = 1'b1;
        issue(3'b000, 32'd7, 32'd6, 5'd11, K_OK, 32'd42, 1'b1, t0);
        wait_drain();
        stub_exc = 1'b0;

        // Flush in WAIT; the late done lands in DRAIN and the next op waits for IDLE.
        issue(3'b000, 32'h0000_1234, 32'd2, 5'd12, K_NONE, 32'h0, 1'b0, t0);
        @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        issue(3'b000, 32'd7, 32'd6, 5'd13, K_OK, 32'd42, 1'b0, t1);
        chk("post_flush_accept", t1, t0 + 4);
        wait_drain();

        stub_hang = 1'b1;
        issue(3'b000, 32'd3, 32'd3, 5'd14, K_TMO, 32'h0, 1'b1, t0);
        wait_drain();
        stub_hang = 1'b0;

        // Flush with a simultaneous writeback handshake drops the response.
        rsp_ready_i = 1'b0;
        issue(3'b000, 32'd2, 32'd2, 5'd15, K_NONE, 32'h0, 1'b0, t0);
        n = 0;
        while (!rsp_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        @(posedge clk_i);
        #1;
        flush_i     = 1'b1;
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        @(negedge clk_i);
        chk("resp_flush_valid", 32'(rsp_valid_o), 32'd0);
        chk("resp_flush_ready", 32'(req_ready_o), 32'd1);
        @(posedge clk_i);
        #1;

        issue(3'b000, 32'd9, 32'd9, 5'd16, K_NONE, 32'h0, 1'b0, t0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        chk_outputs_zero("midwait_reset");
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_reset_ready", 32'(req_ready_o), 32'd1);
        chk("post_reset_valid", 32'(rsp_valid_o), 32'd0);
        @(posedge clk_i);
        #1;

        issue(3'b000, 32'd7, 32'd6, 5'd1, K_OK, 32'd42, 1'b0, t0);
        wait_drain();
        repeat (4) @(posedge clk_i);
        #1;
        chk("start_count", starts_seen, starts_exp);
        chk("start_queue_left", exp_start_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
